// File: rtl/nios2_cpu_pio_out_pulse.sv
// Avalon-MM output PIO with set/clear aliases and a timed XOR pulse overlay.
// A PULSE write inverts the masked pins for PULSE_CYCLES clocks; retriggering flags overrun.
module nios2_cpu_pio_out_pulse #(
    parameter int unsigned            DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0]  RESET_VALUE  = '0,
    parameter int unsigned            PULSE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PULSE    = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pulse_state_t;

    pulse_state_t            state, state_next;
    logic [DATA_WIDTH-1:0]   data_out, data_next;
    logic [DATA_WIDTH-1:0]   pulse_mask, mask_next;
    logic [CNT_W-1:0]        count, count_next;
    logic                    overrun, overrun_next;
    logic                    busy;
    logic                    wr;
    logic                    pulse_wr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    unused_writedata;

    assign busy     = (state == ACTIVE);
    assign wr       = chipselect & ~write_n;
    assign pulse_wr = wr & (address == ADDR_PULSE);
    assign wdata    = writedata[DATA_WIDTH-1:0];

    // Upper writedata bits are meaningless for narrow ports.
    assign unused_writedata = ^writedata;

    // Next-state for the data register, status flag and pulse FSM.
    always_comb begin
        data_next    = data_out;
        mask_next    = pulse_mask;
        count_next   = count;
        overrun_next = overrun;
        state_next   = state;

        if (wr) begin
            case (address)
                ADDR_DATA:     data_next = wdata;
                ADDR_OUTSET:   data_next = data_out | wdata;
                ADDR_OUTCLEAR: data_next = data_out & ~wdata;
                ADDR_STATUS:   if (writedata[1]) overrun_next = 1'b0;
                default:       data_next = data_out;
            endcase
        end

        case (state)
            IDLE: begin
                if (pulse_wr) begin
                    state_next = ACTIVE;
                    mask_next  = wdata;
                    count_next = PULSE_LOAD;
                end
            end
            ACTIVE: begin
                if (pulse_wr) begin
                    overrun_next = 1'b1;
                    mask_next    = wdata;
                    count_next   = PULSE_LOAD;
                end else if (count <= CNT_W'(1)) begin
                    // Last pulse cycle; a zero count here is defensive only.
                    state_next = IDLE;
                    mask_next  = '0;
                    count_next = '0;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
                count_next = '0;
            end
        endcase
    end

    // Register file and pins; the mask is zero whenever idle so XOR gives the overlay.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            data_out   <= RESET_VALUE;
            pulse_mask <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            out_port   <= RESET_VALUE;
        end else begin
            state      <= state_next;
            data_out   <= data_next;
            pulse_mask <= mask_next;
            count      <= count_next;
            overrun    <= overrun_next;
            out_port   <= data_next ^ mask_next;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_out);
            ADDR_PULSE:  readdata = 32'(pulse_mask);
            ADDR_STATUS: readdata = {30'b0, overrun, busy};
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios2_cpu_pio_out_pulse.sv
// Bench for nios2_cpu_pio_out_pulse: directed literal checks plus randomized traffic
// checked every cycle against a remaining-cycles behavioural model.
module tb_nios2_cpu_pio_out_pulse;

    localparam int unsigned     DW  = 8;
    localparam logic [DW-1:0]   RV  = 8'hA5;
    localparam int unsigned     PC  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int n_checks = 0;
    int n_pass   = 0;
    bit en_cmp   = 1'b0;

    // Model: pin register, active mask, pulse cycles still to show, overrun flag.
    logic [DW-1:0] m_data = RV;
    logic [DW-1:0] m_mask = '0;
    int            m_rem  = 0;
    bit            m_ovr  = 1'b0;

    nios2_cpu_pio_out_pulse #(
        .DATA_WIDTH   (DW),
        .RESET_VALUE  (RV),
        .PULSE_CYCLES (PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_data = RV;
            m_mask = '0;
            m_rem  = 0;
            m_ovr  = 1'b0;
        end else begin
            bit w;
            w = chipselect && !write_n;
            if (w && address == 3'd2) begin
                if (m_rem > 0) m_ovr = 1'b1;
                m_mask = writedata[DW-1:0];
                m_rem  = PC;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mask = '0;
            end
            if (w) begin
                case (address)
                    3'd0: m_data = writedata[DW-1:0];
                    3'd4: m_data = m_data | writedata[DW-1:0];
                    3'd5: m_data = m_data & ~writedata[DW-1:0];
                    3'd3: if (writedata[1]) m_ovr = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd2:    return 32'(m_mask);
            3'd3:    return {30'b0, m_ovr, (m_rem > 0)};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (en_cmp) begin
            chk("cmp_out_port", 32'(out_port), (m_rem > 0) ? 32'(m_data ^ m_mask) : 32'(m_data));
            chk("cmp_readdata", readdata, model_read(address));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(name, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick();
        tick();
        reset  = 1'b0;
        en_cmp = 1'b1;

        chk("reset_out", 32'(out_port), 32'h0000_00A5);
        rd_chk("reset_status", 3'd3, 32'h0);

        wr(3'd0, 32'h0000_000F);
        chk("data_out", 32'(out_port), 32'h0F);
        wr(3'd4, 32'h0000_00F0);
        chk("outset_out", 32'(out_port), 32'hFF);
        rd_chk("outset_read", 3'd4, 32'h0);
        wr(3'd5, 32'h0000_0003);
        chk("outclear_out", 32'(out_port), 32'hFC);
        rd_chk("data_read", 3'd0, 32'hFC);

        wr(3'd0, 32'h0);
        wr(3'd2, 32'h0000_0081);
        for (int i = 0; i < 4; i++) begin
            chk("pulse_out", 32'(out_port), 32'h81);
            rd_chk("pulse_busy", 3'd3, 32'h1);
            tick();
        end
        chk("pulse_end_out", 32'(out_port), 32'h00);
        rd_chk("pulse_end_status", 3'd3, 32'h0);
        rd_chk("pulse_end_mask", 3'd2, 32'h0);

        wr(3'd2, 32'h0000_0001);
        chk("retrig_first", 32'(out_port), 32'h01);
        tick();
        wr(3'd2, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            chk("retrig_out", 32'(out_port), 32'h02);
            tick();
        end
        chk("retrig_end_out", 32'(out_port), 32'h00);
        rd_chk("retrig_overrun", 3'd3, 32'h2);
        wr(3'd3, 32'h0000_0002);
        rd_chk("overrun_clear", 3'd3, 32'h0);

        wr(3'd2, 32'h0000_003C);
        tick();
        chk("mid_pulse_out", 32'(out_port), 32'h3C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_abort_out", 32'(out_port), 32'hA5);
        rd_chk("reset_abort_status", 3'd3, 32'h0);
        rd_chk("reset_abort_mask", 3'd2, 32'h0);

        wr(3'd6, 32'hFFFF_FFFF);
        rd_chk("unmapped_1", 3'd1, 32'h0);
        rd_chk("unmapped_6", 3'd6, 32'h0);
        rd_chk("unmapped_7", 3'd7, 32'h0);
        chk("unmapped_out", 32'(out_port), 32'hA5);

        for (int i = 0; i < 3000; i++) begin
            address    = 3'($urandom_range(7));
            chipselect = ($urandom_range(1) == 1);
            write_n    = ($urandom_range(2) == 0);
            writedata  = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            reset      = ($urandom_range(99) == 0);
            tick();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nios2_cpu_pio_out_pulse.md
NIOS2_CPU_PIO_OUT_PULSE -- requirements
Module: nios2_cpu_pio_out_pulse

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning output port width in bits (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, meaning the value data_out takes on reset (DATA_WIDTH bits).
REQ-003 The block SHALL have parameter PULSE_CYCLES, default 16, meaning pulse duration in clk cycles (legal range 1..65535).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port address, input, 3, the Avalon-MM word address.
REQ-008 The block SHALL have port chipselect, input, 1, the slave select.
REQ-009 The block SHALL have port write_n, input, 1, the active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32, the write data.
REQ-011 The block SHALL have port readdata, output, 32, combinational read data with zero read latency.
REQ-012 The block SHALL have port out_port, output, DATA_WIDTH, the driven output pins.

Function
REQ-013 The block SHALL treat a write as chipselect=1 and write_n=0 sampled at a rising clk edge; writes SHALL take effect at that edge.
REQ-014 Address 0 (DATA, R/W) SHALL be handled as follows: write sets data_out <= writedata[DATA_WIDTH-1:0]; read returns data_out.
REQ-015 Address 4 (OUTSET, W) SHALL be handled as follows: write sets data_out <= data_out | writedata[DATA_WIDTH-1:0]; read returns 0.
REQ-016 Address 5 (OUTCLEAR, W) SHALL be handled as follows: write sets data_out <= data_out & ~writedata[DATA_WIDTH-1:0]; read returns 0.
REQ-017 Address 2 (PULSE, R/W) SHALL be handled as follows: write loads pulse_mask <= writedata[DATA_WIDTH-1:0], loads count <= PULSE_CYCLES and sets busy=1; read returns pulse_mask.
REQ-018 Address 3 (STATUS) SHALL be handled as follows: read returns {30'b0, overrun, busy}; a write with writedata[1]=1 clears overrun, and all other bits are ignored.
REQ-019 Addresses 1, 6 and 7 SHALL read 0 and SHALL ignore writes.
REQ-020 Readdata bits [31:DATA_WIDTH] SHALL read 0 for the DATA and PULSE registers.
REQ-021 While busy=1, out_port SHALL equal data_out ^ pulse_mask; while busy=0, out_port SHALL equal data_out.
REQ-022 Pulse timing: after the PULSE write edge, out_port SHALL show the inverted bits for exactly PULSE_CYCLES clk periods.
REQ-023 Pulse state machine, IDLE (busy=0) -> ACTIVE (busy=1): the transition SHALL occur on a PULSE write.
REQ-024 Pulse state machine, in ACTIVE: count SHALL decrement by 1 each cycle.
REQ-025 Pulse state machine, ACTIVE -> IDLE: on the edge where count==1 and no PULSE write occurs, busy <= 0, pulse_mask <= 0 and count <= 0.
REQ-026 Counter width SHALL be 16 bits, and count SHALL never wrap below 0.
REQ-027 A PULSE write while busy=1 (including the final count==1 cycle) SHALL set overrun=1, reload pulse_mask and count, and keep busy=1 (retrigger).
REQ-028 A PULSE write with writedata[DATA_WIDTH-1:0]==0 SHALL still start a pulse (busy=1 for PULSE_CYCLES) with no visible change on out_port.
REQ-029 A STATUS clear write and an overrun-setting event SHALL NOT coincide, since only one address is written per cycle.
REQ-030 DATA, OUTSET and OUTCLEAR writes during a pulse SHALL modify data_out only; the XOR overlay continues unchanged.

Reset
REQ-031 When reset=1 at a clk edge, the block SHALL set data_out <= RESET_VALUE, pulse_mask <= 0, count <= 0, busy <= 0 and overrun <= 0.
REQ-032 Reset SHALL take priority over any simultaneous write.
REQ-033 Reset during an active pulse SHALL abort the pulse immediately, so that out_port equals RESET_VALUE after that edge.
REQ-034 Readdata SHALL remain combinational during reset and SHALL reflect the register state.

Verification
REQ-035 The bench SHALL cover reset with DATA_WIDTH=8 and RESET_VALUE=8'hA5: after reset, out_port=8'hA5 and readdata at address 3 = 0.
REQ-036 The bench SHALL cover the following sequence: write DATA=8'h0F, then OUTSET=8'hF0, then OUTCLEAR=8'h03. Required response: out_port = 8'h0F, then 8'hFF, then 8'hFC; address 4 reads 0.
REQ-037 The bench SHALL cover the following case: with PULSE_CYCLES=4 and data_out=8'h00, write PULSE=8'h81. Required response: out_port=8'h81 for exactly 4 cycles, then 8'h00; busy goes 1 then 0; overrun stays 0.
REQ-038 The bench SHALL cover the following case: with PULSE_CYCLES=4, write PULSE=8'h01, then write PULSE=8'h02 two cycles later. Required response: out_port shows 8'h02 for 4 cycles from the second write; overrun=1; a STATUS write of 32'h2 clears it.
REQ-039 The bench SHALL cover the following case: assert reset mid-pulse with DATA_WIDTH=8 and RESET_VALUE=8'hA5. Required response: out_port=8'hA5 on the next edge, busy=0 and the PULSE register reads 0.
REQ-040 The bench SHALL cover the following case: write 32'hFFFF_FFFF to address 6, then read addresses 1, 6 and 7. Required response: all reads return 0 and out_port is unchanged.
